// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states
// and the datapath select encodings.
`default_nettype none

package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: sequences each instruction through its states,
// drives datapath selects/enables, traps illegal opcodes and counts retirements.
`default_nettype none

module multicycle_control_unit
  import control_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE   = 1'b1,
  parameter bit          ENABLE_BNE      = 1'b1,
  parameter bit          ENABLE_ADDI     = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_instr,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q;
  logic             w_ready;

  assign w_ready       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign retired_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (instr_retired) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (w_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE:       state_d = ENABLE_BNE ? S_BRANCH : S_TRAP;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDI_EX : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (w_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (w_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      S_TRAP:     if (!TRAP_ON_ILLEGAL) state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_instr = 1'b0;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR load and PC+4 commit only once the fetch read completes
        ir_write  = w_ready;
        pc_write  = w_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEM_WR: begin
        mem_write     = 1'b1;
        i_or_d        = 1'b1;
        instr_retired = w_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        reg_dst       = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (op_q == OP_BNE);
        instr_retired = 1'b1;
      end
      S_JUMP: begin
        pc_write      = 1'b1;
        pc_source     = PCSRC_JUMP;
        instr_retired = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit across four
// parameterisations driven from shared stimulus.
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h3f;
  logic       mem_ready = 1'b1;

  logic [3:0][18:0] ctl;
  logic [3:0][31:0] cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: no BNE, 2: 4-bit counter, 3: no handshake + non-sticky trap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 2) ? 4 : 32;
    logic pw, pwc, bne, iord, irw, mr, mw, rd, m2r, rw, asa, ill, ret;
    logic [1:0] asb, aop, ps;

    multicycle_control_unit #(
      .MEM_HANDSHAKE  ((g == 3) ? 1'b0 : 1'b1),
      .ENABLE_BNE     ((g == 1) ? 1'b0 : 1'b1),
      .ENABLE_ADDI    (1'b1),
      .TRAP_ON_ILLEGAL((g == 3) ? 1'b0 : 1'b1),
      .CNT_W          (W)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pc_write     (pw),
      .pc_write_cond(pwc),
      .branch_ne    (bne),
      .i_or_d       (iord),
      .ir_write     (irw),
      .mem_read     (mr),
      .mem_write    (mw),
      .reg_dst      (rd),
      .mem_to_reg   (m2r),
      .reg_write    (rw),
      .alu_src_a    (asa),
      .alu_src_b    (asb),
      .alu_op       (aop),
      .pc_source    (ps),
      .illegal_instr(ill),
      .instr_retired(ret),
      .retired_count(cnt[g][W-1:0])
    );

    assign ctl[g] = {pw, pwc, bne, iord, irw, mr, mw, rd, m2r, rw, asa, asb, aop, ps, ill, ret};
    if (g == 2) begin : g_narrow
      assign cnt[g][31:4] = '0;
    end
  end

  function automatic logic [18:0] mk(
    input logic pcw, pcwc, bn, iord, irw, mr, mw, rd, m2r, rw, asa,
    input logic [1:0] asb, aop, ps,
    input logic ill, ret);
    return {pcw, pcwc, bn, iord, irw, mr, mw, rd, m2r, rw, asa, asb, aop, ps, ill, ret};
  endfunction

  logic [18:0] E_FETCH, E_FWAIT, E_DEC, E_EXEC, E_ALUWB, E_MADDR, E_MRD, E_MWB;
  logic [18:0] E_MWR_WAIT, E_MWR_DONE, E_BEQ, E_BNE, E_JUMP, E_ADDIWB, E_TRAP;

  task automatic cyc(input logic r, input logic [5:0] op);
    @(posedge clk);
    #1;
    mem_ready = r;
    opcode    = op;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    opcode    = 6'h3f;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    for (int g = 0; g < 4; g++) begin
      n_total++;
      if (ctl[g] !== 19'd0 || cnt[g] !== 32'd0) $display("FAIL reset dut%0d: ctl=%h cnt=%0d want ctl=0 cnt=0", g, ctl[g], cnt[g]);
      else n_pass++;
    end
    do_reset();
    n_total++;
    if (ctl[0] !== 19'd0) $display("FAIL idle_after_release: ctl=%h want 0", ctl[0]);
    else n_pass++;
  endtask

  task automatic test_rtype();
    logic [18:0] ex [4];
    logic [5:0]  op [4];
    ex = '{E_FETCH, E_DEC, E_EXEC, E_ALUWB};
    op = '{6'h3f, 6'h00, 6'h3f, 6'h3f};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, op[i]);
      n_total++;
      if (ctl[0] !== ex[i]) $display("FAIL rtype cyc%0d: ctl=%h want %h", i, ctl[0], ex[i]);
      else n_pass++;
    end
    cyc(1'b1, 6'h3f);
    n_total++;
    if (cnt[0] !== 32'd1) $display("FAIL rtype_count: got %0d want 1", cnt[0]);
    else n_pass++;
  endtask

  task automatic test_lw_wait();
    logic [18:0] ex [7];
    logic [5:0]  op [7];
    logic        rd [7];
    ex = '{E_FETCH, E_DEC, E_MADDR, E_MRD, E_MRD, E_MRD, E_MWB};
    op = '{6'h3f, 6'h23, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(rd[i], op[i]);
      n_total++;
      if (ctl[0] !== ex[i]) $display("FAIL lw cyc%0d: ctl=%h want %h", i, ctl[0], ex[i]);
      else n_pass++;
    end
    cyc(1'b1, 6'h3f);
    n_total++;
    if (cnt[0] !== 32'd1 || ctl[0] !== E_FETCH) $display("FAIL lw_done: cnt=%0d ctl=%h want cnt=1 ctl=%h", cnt[0], ctl[0], E_FETCH);
    else n_pass++;
  endtask

  task automatic test_bne_and_trap();
    logic [18:0] ex0 [3];
    logic [18:0] ex1 [3];
    logic [5:0]  op  [3];
    ex0 = '{E_FETCH, E_DEC, E_BNE};
    ex1 = '{E_FETCH, E_DEC, E_TRAP};
    op  = '{6'h3f, 6'h05, 6'h3f};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, op[i]);
      n_total++;
      if (ctl[0] !== ex0[i]) $display("FAIL bne cyc%0d: ctl=%h want %h", i, ctl[0], ex0[i]);
      else n_pass++;
      n_total++;
      if (ctl[1] !== ex1[i]) $display("FAIL bne_disabled cyc%0d: ctl=%h want %h", i, ctl[1], ex1[i]);
      else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 6'h00);
      n_total++;
      if (ctl[1] !== E_TRAP) $display("FAIL trap_hold cyc%0d: ctl=%h want %h", i, ctl[1], E_TRAP);
      else n_pass++;
    end
    n_total++;
    if (cnt[1] !== 32'd0 || cnt[0] === 32'd0) $display("FAIL trap_count: trapped=%0d want 0, bne=%0d want nonzero", cnt[1], cnt[0]);
    else n_pass++;
  endtask

  task automatic test_illegal_flag();
    logic [18:0] ex [4];
    ex = '{E_FETCH, E_DEC, E_TRAP, E_FETCH};
    do_reset();
    // mem_ready held low: the no-handshake instance must ignore it
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 6'h3f);
      n_total++;
      if (ctl[3] !== ex[i]) $display("FAIL illegal_flag cyc%0d: ctl=%h want %h", i, ctl[3], ex[i]);
      else n_pass++;
    end
    n_total++;
    if (cnt[3] !== 32'd0) $display("FAIL illegal_count: got %0d want 0", cnt[3]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] ex [12];
    logic [5:0]  op [12];
    logic        rd [12];
    ex = '{E_FWAIT, E_FETCH, E_DEC, E_MADDR, E_ADDIWB,
           E_FETCH, E_DEC, E_BEQ,
           E_FETCH, E_DEC, E_MADDR, E_MWR_DONE};
    op = '{6'h3f, 6'h3f, 6'h08, 6'h3f, 6'h3f,
           6'h3f, 6'h04, 6'h3f,
           6'h3f, 6'h2b, 6'h3f, 6'h3f};
    rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(rd[i], op[i]);
      n_total++;
      if (ctl[0] !== ex[i]) $display("FAIL b2b cyc%0d: ctl=%h want %h", i, ctl[0], ex[i]);
      else n_pass++;
    end
    cyc(1'b1, 6'h3f);
    n_total++;
    if (cnt[0] !== 32'd3) $display("FAIL b2b_count: got %0d want 3", cnt[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(1'b1, (k == 1) ? 6'h02 : 6'h3f);
        n_total++;
        if (ctl[2][0] !== (k == 2)) $display("FAIL wrap_retire j%0d k%0d: got %b want %b", j, k, ctl[2][0], (k == 2));
        else n_pass++;
        if (k == 0) begin
          n_total++;
          if (cnt[2] !== 32'(j)) $display("FAIL wrap_count j%0d: got %0d want %0d", j, cnt[2], j);
          else n_pass++;
        end
      end
    end
    cyc(1'b1, 6'h3f);
    n_total++;
    if (cnt[2] !== 32'd0 || cnt[0] !== 32'd16) $display("FAIL wrap_final: narrow=%0d want 0, wide=%0d want 16", cnt[2], cnt[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [18:0] ex [8];
    logic [5:0]  op [8];
    logic        rd [8];
    ex = '{E_FETCH, E_DEC, E_JUMP, E_FETCH, E_DEC, E_MADDR, E_MWR_WAIT, E_MWR_WAIT};
    op = '{6'h3f, 6'h02, 6'h3f, 6'h3f, 6'h2b, 6'h3f, 6'h3f, 6'h3f};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(rd[i], op[i]);
      n_total++;
      if (ctl[0] !== ex[i]) $display("FAIL sw_wait cyc%0d: ctl=%h want %h", i, ctl[0], ex[i]);
      else n_pass++;
    end
    n_total++;
    if (cnt[0] !== 32'd1) $display("FAIL pre_reset_count: got %0d want 1", cnt[0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ctl[0] !== 19'd0 || cnt[0] !== 32'd0) $display("FAIL async_reset: ctl=%h cnt=%0d want 0/0", ctl[0], cnt[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (ctl[0] !== 19'd0) $display("FAIL idle_after_mid_reset: ctl=%h want 0", ctl[0]);
    else n_pass++;
    cyc(1'b1, 6'h3f);
    n_total++;
    if (ctl[0] !== E_FETCH) $display("FAIL fetch_after_mid_reset: ctl=%h want %h", ctl[0], E_FETCH);
    else n_pass++;
  endtask

  initial begin
    E_FETCH    = mk(1,0,0,0,1,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    E_FWAIT    = mk(0,0,0,0,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    E_DEC      = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    E_EXEC     = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
    E_ALUWB    = mk(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0,1);
    E_MADDR    = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    E_MRD      = mk(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_MWB      = mk(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0,1);
    E_MWR_WAIT = mk(0,0,0,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_MWR_DONE = mk(0,0,0,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,1);
    E_BEQ      = mk(0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,1);
    E_BNE      = mk(0,1,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0,1);
    E_JUMP     = mk(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0,1);
    E_ADDIWB   = mk(0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0,1);
    E_TRAP     = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);

    test_reset();
    test_rtype();
    test_lw_wait();
    test_bne_and_trap();
    test_illegal_flag();
    test_back_to_back();
    test_wrap();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
